nmc_initiator: RTL

- Host-side initiator for the nmc block. Accepts write and query commands from upstream over valid/ready.
- Drives the nmc write-request and query-request FIFO push interfaces, respecting their full flags.
- Captures every single-cycle nmc_qr_resp pulse into a credit-protected response buffer and returns results upstream over valid/ready.
- Enforces a write fence: nmc services pending writes ahead of queued queries, so without the fence a later write could overtake an earlier query.

---
 rtl/nmc_initiator_pkg.sv | 46 ++++
 rtl/nmc_initiator_if.sv | 35 +++
 rtl/nmc_initiator_fifo.sv | 57 +++++
 rtl/nmc_initiator.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/nmc_initiator_pkg.sv
// Shared types for the nmc host-side initiator: request/response payloads and
// staging-register layouts.
package nmc_initiator_pkg;

  localparam int unsigned AddrW   = 8;
  localparam int unsigned EntryW  = 16;
  localparam int unsigned IdW     = 4;
  localparam int unsigned FeatW   = 16;
  localparam int unsigned ResultW = 16;

  typedef logic [ResultW-1:0] result_t;

  typedef struct packed {
    logic [AddrW-1:0]  addr;
    logic [EntryW-1:0] entry;
  } nmc_wr_req_t;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [IdW-1:0]   id;
    logic             id_vld;
    logic [FeatW-1:0] feature;
  } nmc_qr_req_t;

  typedef struct packed {
    logic    valid;
    logic    found;
    result_t result;
  } nmc_qr_resp_t;

  typedef struct packed {
    logic    found;
    result_t result;
  } nmc_res_t;

  typedef struct packed {
    logic        vld;
    nmc_wr_req_t data;
  } wr_stage_t;

  typedef struct packed {
    logic        vld;
    nmc_qr_req_t data;
  } qr_stage_t;

endpackage

// File: rtl/nmc_initiator_if.sv
// Upstream command/result handshakes plus the nmc FIFO push and response signals.
interface nmc_initiator_if;
  import nmc_initiator_pkg::*;

  logic         wr_cmd_vld;
  logic         wr_cmd_rdy;
  nmc_wr_req_t  wr_cmd;
  logic         qr_cmd_vld;
  logic         qr_cmd_rdy;
  nmc_qr_req_t  qr_cmd;
  logic         res_vld;
  logic         res_rdy;
  logic         res_found;
  result_t      res_result;
  nmc_wr_req_t  nmc_wr_req;
  logic         nwr_push;
  logic         nwr_full;
  nmc_qr_req_t  nmc_qr_req;
  logic         nqr_push;
  logic         nqr_full;
  nmc_qr_resp_t nmc_qr_resp;

  modport master (
    input  wr_cmd_vld, wr_cmd, qr_cmd_vld, qr_cmd, res_rdy, nwr_full, nqr_full, nmc_qr_resp,
    output wr_cmd_rdy, qr_cmd_rdy, res_vld, res_found, res_result, nmc_wr_req, nwr_push,
           nmc_qr_req, nqr_push
  );

  modport slave (
    output wr_cmd_vld, wr_cmd, qr_cmd_vld, qr_cmd, res_rdy, nwr_full, nqr_full, nmc_qr_resp,
    input  wr_cmd_rdy, qr_cmd_rdy, res_vld, res_found, res_result, nmc_wr_req, nwr_push,
           nmc_qr_req, nqr_push
  );

endinterface

// File: rtl/nmc_initiator_fifo.sv
// Synchronous show-ahead FIFO; head data is valid whenever empty_o is low.
module nmc_initiator_fifo #(
  parameter type         fifo_t     = logic,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push_i,
  input  fifo_t data_i,
  input  logic  pop_i,
  output fifo_t data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW+1)'(FIFO_DEPTH);

  fifo_t           mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            push_ok, pop_ok;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
    if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
    else if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/nmc_initiator.sv
// Host-side nmc initiator: stages write/query commands, fences writes behind
// in-flight queries, and buffers query responses under credit control.
module nmc_initiator
  import nmc_initiator_pkg::*;
#(
  parameter int unsigned RESP_DEPTH = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  nmc_initiator_if.master  bus,
  output logic             busy_o,
  output logic [CNT_W-1:0] found_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic             err_o
);

  localparam int unsigned    CrW   = $clog2(RESP_DEPTH) + 1;
  localparam logic [CrW-1:0] CrMax = CrW'(RESP_DEPTH);

  wr_stage_t        wr_s_q, wr_s_d;
  qr_stage_t        qr_s_q, qr_s_d;
  logic [CrW-1:0]   cred_q, cred_d;
  logic [CrW-1:0]   out_q, out_d;
  logic [CNT_W-1:0] found_q, found_d, miss_q, miss_d;
  logic             err_q, err_d;

  logic     fence_clear, nwr_push, nqr_push, wr_cmd_rdy, qr_cmd_rdy;
  logic     wr_cmd_fire, qr_cmd_fire, res_fire;
  logic     resp_vld, resp_unexp, resp_dec, resp_keep;
  logic     fifo_full, fifo_empty;
  nmc_res_t resp_entry, res_head;

  // Queries must all be answered before a write may enter, since nmc
  // would otherwise service the write ahead of an earlier query.
  assign fence_clear = (out_q == '0) & ~qr_s_q.vld;
  assign nwr_push    = wr_s_q.vld & ~bus.nwr_full;
  assign wr_cmd_rdy  = (~wr_s_q.vld | nwr_push) & fence_clear;
  assign wr_cmd_fire = bus.wr_cmd_vld & wr_cmd_rdy;

  assign nqr_push    = qr_s_q.vld & ~bus.nqr_full;
  assign qr_cmd_rdy  = (~qr_s_q.vld | nqr_push) & (cred_q != '0) & ~wr_cmd_fire;
  assign qr_cmd_fire = bus.qr_cmd_vld & qr_cmd_rdy;

  assign res_fire   = ~fifo_empty & bus.res_rdy;
  assign resp_vld   = bus.nmc_qr_resp.valid;
  assign resp_unexp = resp_vld & (out_q == '0);
  assign resp_dec   = resp_vld & ~resp_unexp;
  assign resp_keep  = resp_dec & ~fifo_full;

  assign resp_entry.found  = bus.nmc_qr_resp.found;
  assign resp_entry.result = bus.nmc_qr_resp.found ? bus.nmc_qr_resp.result : '0;

  nmc_initiator_fifo #(
    .fifo_t     (nmc_res_t),
    .FIFO_DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (resp_keep),
    .data_i  (resp_entry),
    .pop_i   (res_fire),
    .data_o  (res_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    wr_s_d = wr_s_q;
    if (wr_cmd_fire) begin
      wr_s_d.vld  = 1'b1;
      wr_s_d.data = bus.wr_cmd;
    end else if (nwr_push) begin
      wr_s_d.vld = 1'b0;
    end

    qr_s_d = qr_s_q;
    if (qr_cmd_fire) begin
      qr_s_d.vld  = 1'b1;
      qr_s_d.data = bus.qr_cmd;
    end else if (nqr_push) begin
      qr_s_d.vld = 1'b0;
    end

    cred_d = cred_q;
    if (qr_cmd_fire && !res_fire) begin
      cred_d = cred_q - 1'b1;
    end else if (res_fire && !qr_cmd_fire && (cred_q != CrMax)) begin
      cred_d = cred_q + 1'b1;
    end

    out_d = out_q;
    if (nqr_push && !resp_dec)      out_d = out_q + 1'b1;
    else if (resp_dec && !nqr_push) out_d = out_q - 1'b1;

    found_d = found_q;
    miss_d  = miss_q;
    if (resp_keep) begin
      if (bus.nmc_qr_resp.found) begin
        if (found_q != '1) found_d = found_q + 1'b1;
      end else if (miss_q != '1) begin
        miss_d = miss_q + 1'b1;
      end
    end

    err_d = err_q | (resp_vld & (resp_unexp | fifo_full));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_s_q  <= '0;
      qr_s_q  <= '0;
      cred_q  <= CrMax;
      out_q   <= '0;
      found_q <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      wr_s_q  <= wr_s_d;
      qr_s_q  <= qr_s_d;
      cred_q  <= cred_d;
      out_q   <= out_d;
      found_q <= found_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
    end
  end

  assign bus.wr_cmd_rdy = wr_cmd_rdy;
  assign bus.qr_cmd_rdy = qr_cmd_rdy;
  assign bus.nwr_push   = nwr_push;
  assign bus.nmc_wr_req = wr_s_q.data;
  assign bus.nqr_push   = nqr_push;
  assign bus.nmc_qr_req = qr_s_q.data;
  assign bus.res_vld    = ~fifo_empty;
  assign bus.res_found  = res_head.found;
  assign bus.res_result = res_head.result;

  assign busy_o      = wr_s_q.vld | qr_s_q.vld | (out_q != '0) | ~fifo_empty;
  assign found_cnt_o = found_q;
  assign miss_cnt_o  = miss_q;
  assign err_o       = err_q;

endmodule
